// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, flag bit positions, FSM states.
// The iterative multiplier is only built when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpCmp = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpOr  = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpMov = 4'd6;
    localparam logic [3:0] OpLsh = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;

    localparam int unsigned FlagC = 4;
    localparam int unsigned FlagL = 3;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagN = 0;

    typedef enum logic {
        StIdle,
        StMulRun
    } state_t;

    // Single-cycle opcodes that produce a register write-back.
    function automatic logic writes_back(logic [3:0] op);
        return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr) ||
               (op == OpXor) || (op == OpMov) || (op == OpLsh);
    endfunction

endpackage

// File: rtl/alu_exec_stage_mul_iter.sv
// Shift-add multiplier: latches operands on start, one iteration per clock, done on the last.
// product is valid combinationally during the cycle done is high (low WIDTH bits only).
module alu_mul_iter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic             running_q;
    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        product  = acc_step;
        done     = running_q && (count_q == CntW'(MUL_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= a;
            mplier_q  <= b;
        end else if (running_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done) begin
                running_q <= 1'b0;
                count_q   <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: registered ALU result, one-cycle write-back strobe and flags {C,L,F,Z,N}.
// Define ALU_MUL_EN to build the 16-cycle iterative multiply (opcode 8); otherwise it is a NOP.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] DestSel,
    output logic [WIDTH-1:0] Result,
    output logic [SEL_W-1:0] WriteBackSelect,
    output logic             WriteBackEnable,
    output logic [4:0]       Flags,
    output logic             Busy
);

    if (MUL_CYCLES != WIDTH) begin : gen_cfg_check
        $error("alu_exec_stage: MUL_CYCLES must equal WIDTH");
    end

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;

    always_comb begin
        add_ext   = {1'b0, A} + {1'b0, B};
        sub_ext   = {1'b0, A} - {1'b0, B};
        alu_res   = Result;
        alu_flags = Flags;
        unique case (Opcode)
            OpAdd: begin
                alu_res          = add_ext[WIDTH-1:0];
                alu_flags[FlagC] = add_ext[WIDTH];
                alu_flags[FlagF] = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
                alu_flags[FlagN] = alu_res[WIDTH-1];
            end
            OpSub: begin
                // Top bit of the zero-extended difference is the unsigned borrow.
                alu_res          = sub_ext[WIDTH-1:0];
                alu_flags[FlagC] = sub_ext[WIDTH];
                alu_flags[FlagF] = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
                alu_flags[FlagN] = alu_res[WIDTH-1];
            end
            OpCmp: begin
                alu_flags[FlagZ] = (A == B);
                alu_flags[FlagL] = (A < B);
                alu_flags[FlagN] = ($signed(A) < $signed(B));
            end
            OpAnd: alu_res = A & B;
            OpOr:  alu_res = A | B;
            OpXor: alu_res = A ^ B;
            OpMov: alu_res = B;
            OpLsh: alu_res = B[4] ? (A >> B[3:0]) : (A << B[3:0]);
            default: ;
        endcase
        if (writes_back(Opcode)) begin
            alu_flags[FlagZ] = (alu_res == '0);
        end
    end

`ifdef ALU_MUL_EN
    state_t           state_q;
    logic [SEL_W-1:0] mul_dest_q;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign InReady   = (state_q == StIdle);
    assign Busy      = (state_q == StMulRun);
    assign mul_start = (state_q == StIdle) && InValid && (Opcode == OpMul);

    alu_mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (Clock),
        .rst     (Reset),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign InReady = 1'b1;
    assign Busy    = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
`ifdef ALU_MUL_EN
            state_q    <= StIdle;
            mul_dest_q <= '0;
`endif
            Result          <= '0;
            WriteBackSelect <= '0;
            WriteBackEnable <= 1'b0;
            Flags           <= '0;
        end else begin
            WriteBackEnable <= 1'b0;
`ifdef ALU_MUL_EN
            if (state_q == StMulRun) begin
                if (mul_done) begin
                    Result           <= mul_product;
                    WriteBackSelect  <= mul_dest_q;
                    WriteBackEnable  <= 1'b1;
                    Flags[FlagZ]     <= (mul_product == '0);
                    state_q          <= StIdle;
                end
            end else if (InValid && (Opcode == OpMul)) begin
                state_q    <= StMulRun;
                mul_dest_q <= DestSel;
            end else
`endif
            if (InValid) begin
                Flags <= alu_flags;
                if (writes_back(Opcode)) begin
                    Result          <= alu_res;
                    WriteBackSelect <= DestSel;
                    WriteBackEnable <= 1'b1;
                end
            end
        end
    end

endmodule
